// File: rtl/rob_nway.sv
// Reorder buffer: WIDTH-lane in-order dispatch/retire, CDB_CH completion ports, branch recovery.
// Latency: retire outputs are registered one cycle after the deciding edge; stall/idx are combinational.
// Backpressure: a dispatch group that does not fit is refused whole; ROB_SELECTIVE_SQUASH_EN keeps pre-branch entries.
module rob_nway #(
    parameter int DEPTH  = 32,
    parameter int WIDTH  = 2,
    parameter int CDB_CH = 2,
    parameter int PREG_W = 6,
    parameter int AREG_W = 5,
    parameter int PKT_W  = 64,
    localparam int IW    = $clog2(DEPTH)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [WIDTH-1:0]              disp_valid_i,
    input  logic [WIDTH-1:0][PREG_W-1:0]  disp_tag_i,
    input  logic [WIDTH-1:0][PREG_W-1:0]  disp_told_i,
    input  logic [WIDTH-1:0][AREG_W-1:0]  disp_arch_i,
    input  logic [WIDTH-1:0][PKT_W-1:0]   disp_pkt_i,
    input  logic [WIDTH-1:0]              disp_halt_i,
    output logic                          disp_stall_o,
    output logic [WIDTH-1:0][IW-1:0]      disp_idx_o,
    input  logic [CDB_CH-1:0]             cdb_valid_i,
    input  logic [CDB_CH-1:0][PREG_W-1:0] cdb_tag_i,
    input  logic                          recover_i,
    input  logic [IW-1:0]                 recover_idx_i,
    output logic [WIDTH-1:0]              retire_en_o,
    output logic [WIDTH-1:0][PREG_W-1:0]  retire_tag_o,
    output logic [WIDTH-1:0][PREG_W-1:0]  retire_told_o,
    output logic [WIDTH-1:0][AREG_W-1:0]  retire_arch_o,
    output logic [WIDTH-1:0][PKT_W-1:0]   retire_pkt_o,
    output logic [IW:0]                   count_o,
    output logic                          empty_o,
    output logic                          full_o
);

    localparam logic [IW:0] DEPTH_C = DEPTH[IW:0];

    logic [IW-1:0]     head_q, tail_q;
    logic [IW:0]       count_q;
    logic [DEPTH-1:0]  valid_q, done_q, halt_q;
    logic [PREG_W-1:0] tag_q  [DEPTH];
    logic [PREG_W-1:0] told_q [DEPTH];
    logic [AREG_W-1:0] arch_q [DEPTH];
    logic [PKT_W-1:0]  pkt_q  [DEPTH];

    logic [IW:0]       n_disp, acc_n, n_ret, count_d;
    logic [IW-1:0]     head_d, tail_d;
    logic              accept, rec_act;
    logic [DEPTH-1:0]  cdb_hit, done_now, ret_mask, squash;
    logic [WIDTH-1:0]  ret_en, lane_allow;

    always_comb begin
        n_disp = '0;
        for (int k = 0; k < WIDTH; k++)
            n_disp = n_disp + {{IW{1'b0}}, disp_valid_i[k]};
    end

    // Stall uses the registered count only; same-cycle retire frees nothing.
    assign disp_stall_o = (n_disp > (DEPTH_C - count_q));
    assign accept       = !disp_stall_o && !recover_i;
    assign acc_n        = accept ? n_disp : '0;
    assign rec_act      = recover_i && valid_q[recover_idx_i];

    always_comb begin
        for (int k = 0; k < WIDTH; k++)
            disp_idx_o[k] = tail_q + IW'(k);
    end

    always_comb begin
        cdb_hit = '0;
        for (int i = 0; i < DEPTH; i++)
            for (int c = 0; c < CDB_CH; c++)
                if (valid_q[i] && cdb_valid_i[c] && (cdb_tag_i[c] == tag_q[i]))
                    cdb_hit[i] = 1'b1;
    end
    assign done_now = done_q | cdb_hit;

`ifdef ROB_SELECTIVE_SQUASH_EN
    logic [IW-1:0] keep_diff;
    logic [IW:0]   keep_cnt;
    assign keep_diff = recover_idx_i - head_q + IW'(1);
    assign keep_cnt  = (keep_diff == '0) ? DEPTH_C : {1'b0, keep_diff};

    always_comb begin
        for (int k = 0; k < WIDTH; k++)
            lane_allow[k] = !rec_act || ((IW+1)'(k) < keep_cnt);
        for (int i = 0; i < DEPTH; i++)
            squash[i] = rec_act && ({1'b0, IW'(i) - head_q} >= keep_cnt);
    end
`else
    always_comb begin
        lane_allow = {WIDTH{!rec_act}};
        squash     = {DEPTH{rec_act}};
    end
`endif

    // In-order retire chain: a gap or a retiring halt stops all higher lanes.
    always_comb begin
        logic          blocked;
        logic [IW-1:0] ridx;
        ret_en   = '0;
        ret_mask = '0;
        n_ret    = '0;
        blocked  = 1'b0;
        ridx     = '0;
        for (int k = 0; k < WIDTH; k++) begin
            ridx = head_q + IW'(k);
            if (!blocked && lane_allow[k] && valid_q[ridx] && done_now[ridx]) begin
                ret_en[k]      = 1'b1;
                ret_mask[ridx] = 1'b1;
                n_ret          = n_ret + (IW+1)'(1);
                if (halt_q[ridx])
                    blocked = 1'b1;
            end else begin
                blocked = 1'b1;
            end
        end
    end

    always_comb begin
        head_d  = head_q + n_ret[IW-1:0];
        tail_d  = tail_q + acc_n[IW-1:0];
        count_d = count_q + acc_n - n_ret;
        if (rec_act) begin
`ifdef ROB_SELECTIVE_SQUASH_EN
            tail_d  = recover_idx_i + IW'(1);
            count_d = keep_cnt - n_ret;
`else
            tail_d  = head_q;
            count_d = '0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            empty_o       <= 1'b1;
            full_o        <= 1'b0;
            valid_q       <= '0;
            done_q        <= '0;
            halt_q        <= '0;
            retire_en_o   <= '0;
            retire_tag_o  <= '0;
            retire_told_o <= '0;
            retire_arch_o <= '0;
            retire_pkt_o  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                tag_q[i]  <= '0;
                told_q[i] <= '0;
                arch_q[i] <= '0;
                pkt_q[i]  <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            empty_o <= (count_d == '0);
            full_o  <= (count_d == DEPTH_C);

            for (int i = 0; i < DEPTH; i++) begin
                if (cdb_hit[i])
                    done_q[i] <= 1'b1;
                if (ret_mask[i] || squash[i]) begin
                    valid_q[i] <= 1'b0;
                    done_q[i]  <= 1'b0;
                end
            end

            for (int k = 0; k < WIDTH; k++) begin
                if (accept && disp_valid_i[k]) begin
                    valid_q[tail_q + IW'(k)] <= 1'b1;
                    done_q[tail_q + IW'(k)]  <= 1'b0;
                    halt_q[tail_q + IW'(k)]  <= disp_halt_i[k];
                    tag_q[tail_q + IW'(k)]   <= disp_tag_i[k];
                    told_q[tail_q + IW'(k)]  <= disp_told_i[k];
                    arch_q[tail_q + IW'(k)]  <= disp_arch_i[k];
                    pkt_q[tail_q + IW'(k)]   <= disp_pkt_i[k];
                end
            end

            retire_en_o <= ret_en;
            for (int k = 0; k < WIDTH; k++) begin
                if (ret_en[k]) begin
                    retire_tag_o[k]  <= tag_q[head_q + IW'(k)];
                    retire_told_o[k] <= told_q[head_q + IW'(k)];
                    retire_arch_o[k] <= arch_q[head_q + IW'(k)];
                    retire_pkt_o[k]  <= pkt_q[head_q + IW'(k)];
                end
            end
        end
    end

    assign count_o = count_q;

endmodule

// File: tb/tb_rob_nway.sv
// Bench for rob_nway: queue-based reference model checked every cycle plus directed literal checks.
`timescale 1ns/1ps
module tb_rob_nway;
    localparam int DEPTH = 32, WIDTH = 2, CDB_CH = 2, PREG_W = 6, AREG_W = 5, PKT_W = 64;
    localparam int IW = $clog2(DEPTH);

    logic clk = 1'b0;
    logic reset;
    logic [WIDTH-1:0]              disp_valid;
    logic [WIDTH-1:0][PREG_W-1:0]  disp_tag, disp_told;
    logic [WIDTH-1:0][AREG_W-1:0]  disp_arch;
    logic [WIDTH-1:0][PKT_W-1:0]   disp_pkt;
    logic [WIDTH-1:0]              disp_halt;
    logic                          disp_stall;
    logic [WIDTH-1:0][IW-1:0]      disp_idx;
    logic [CDB_CH-1:0]             cdb_valid;
    logic [CDB_CH-1:0][PREG_W-1:0] cdb_tag;
    logic                          recover;
    logic [IW-1:0]                 recover_idx;
    logic [WIDTH-1:0]              retire_en;
    logic [WIDTH-1:0][PREG_W-1:0]  retire_tag, retire_told;
    logic [WIDTH-1:0][AREG_W-1:0]  retire_arch;
    logic [WIDTH-1:0][PKT_W-1:0]   retire_pkt;
    logic [IW:0]                   count;
    logic                          empty, full;

    int total = 0;
    int bad   = 0;

    rob_nway #(.DEPTH(DEPTH), .WIDTH(WIDTH), .CDB_CH(CDB_CH), .PREG_W(PREG_W),
               .AREG_W(AREG_W), .PKT_W(PKT_W)) dut (
        .clk(clk), .reset(reset),
        .disp_valid_i(disp_valid), .disp_tag_i(disp_tag), .disp_told_i(disp_told),
        .disp_arch_i(disp_arch), .disp_pkt_i(disp_pkt), .disp_halt_i(disp_halt),
        .disp_stall_o(disp_stall), .disp_idx_o(disp_idx),
        .cdb_valid_i(cdb_valid), .cdb_tag_i(cdb_tag),
        .recover_i(recover), .recover_idx_i(recover_idx),
        .retire_en_o(retire_en), .retire_tag_o(retire_tag), .retire_told_o(retire_told),
        .retire_arch_o(retire_arch), .retire_pkt_o(retire_pkt),
        .count_o(count), .empty_o(empty), .full_o(full)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the ROB as an ordered queue of live entries, oldest first.
    typedef struct {
        logic [PREG_W-1:0] tag;
        logic [PREG_W-1:0] told;
        logic [AREG_W-1:0] arch;
        logic [PKT_W-1:0]  pkt;
        logic              halt;
        logic              done;
    } ent_t;

    ent_t              q[$];
    ent_t              ne;
    int                m_head;
    bit                m_ok = 1'b0;
    int                m_n, m_p, m_r, m_lim;
    bit                m_stop, m_stall;
    logic [WIDTH-1:0]  e_en;
    logic [PREG_W-1:0] e_tag [WIDTH];
    logic [PREG_W-1:0] e_told[WIDTH];
    logic [AREG_W-1:0] e_arch[WIDTH];
    logic [PKT_W-1:0]  e_pkt [WIDTH];
    int                e_count;
    bit                e_empty, e_full;

    always @(negedge clk) begin
        if (m_ok) begin
            chk("m_ret_en", retire_en, e_en);
            for (int k = 0; k < WIDTH; k++) begin
                chk($sformatf("m_tag%0d", k), retire_tag[k], e_tag[k]);
                chk($sformatf("m_told%0d", k), retire_told[k], e_told[k]);
                chk($sformatf("m_arch%0d", k), retire_arch[k], e_arch[k]);
                chk($sformatf("m_pkt%0d", k), retire_pkt[k], e_pkt[k]);
            end
            chk("m_count", count, e_count);
            chk("m_empty", empty, e_empty);
            chk("m_full", full, e_full);
            if (!reset) begin
                m_n = 0;
                for (int k = 0; k < WIDTH; k++) m_n += int'(disp_valid[k]);
                chk("m_stall", disp_stall, (m_n > DEPTH - q.size()));
                for (int k = 0; k < WIDTH; k++)
                    chk($sformatf("m_idx%0d", k), disp_idx[k], (m_head + q.size() + k) % DEPTH);
            end
        end

        if (reset) begin
            q.delete();
            m_head = 0;
            e_en = '0;
            for (int k = 0; k < WIDTH; k++) begin
                e_tag[k] = '0; e_told[k] = '0; e_arch[k] = '0; e_pkt[k] = '0;
            end
            e_count = 0; e_empty = 1'b1; e_full = 1'b0;
            m_ok = 1'b1;
        end else if (m_ok) begin
            m_n = 0;
            for (int k = 0; k < WIDTH; k++) m_n += int'(disp_valid[k]);
            m_stall = (m_n > DEPTH - q.size());
            foreach (q[i])
                for (int c = 0; c < CDB_CH; c++)
                    if (cdb_valid[c] && cdb_tag[c] == q[i].tag) q[i].done = 1'b1;
            m_p = -1;
            if (recover)
                for (int i = 0; i < q.size(); i++)
                    if ((m_head + i) % DEPTH == int'(recover_idx)) m_p = i;
            m_lim = WIDTH;
`ifdef ROB_SELECTIVE_SQUASH_EN
            if (m_p >= 0 && m_p + 1 < WIDTH) m_lim = m_p + 1;
`else
            if (m_p >= 0) m_lim = 0;
`endif
            e_en = '0; m_r = 0; m_stop = 1'b0;
            for (int k = 0; k < m_lim; k++) begin
                if (!m_stop) begin
                    if (k < q.size() && q[k].done) begin
                        e_en[k] = 1'b1;
                        e_tag[k] = q[k].tag; e_told[k] = q[k].told;
                        e_arch[k] = q[k].arch; e_pkt[k] = q[k].pkt;
                        m_r++;
                        if (q[k].halt) m_stop = 1'b1;
                    end else begin
                        m_stop = 1'b1;
                    end
                end
            end
            for (int i = 0; i < m_r; i++) void'(q.pop_front());
            m_head = (m_head + m_r) % DEPTH;
            if (m_p >= 0) begin
`ifdef ROB_SELECTIVE_SQUASH_EN
                while (q.size() > m_p + 1 - m_r) void'(q.pop_back());
`else
                q.delete();
`endif
            end
            if (!recover && !m_stall)
                for (int k = 0; k < WIDTH; k++)
                    if (disp_valid[k]) begin
                        ne.tag = disp_tag[k]; ne.told = disp_told[k]; ne.arch = disp_arch[k];
                        ne.pkt = disp_pkt[k]; ne.halt = disp_halt[k]; ne.done = 1'b0;
                        q.push_back(ne);
                    end
            e_count = q.size();
            e_empty = (q.size() == 0);
            e_full  = (q.size() == DEPTH);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        disp_valid = '0; disp_halt = '0; cdb_valid = '0; recover = 1'b0;
    endtask

    task automatic lane(input int k, input int t, input bit h);
        disp_valid[k] = 1'b1;
        disp_tag[k]   = PREG_W'(t);
        disp_told[k]  = PREG_W'(t + 17);
        disp_arch[k]  = AREG_W'(t * 3);
        disp_pkt[k]   = {32'hC0DE0000 + 32'(k), 32'(t)};
        disp_halt[k]  = h;
    endtask

    task automatic cdb_set(input int c, input int t);
        cdb_valid[c] = 1'b1;
        cdb_tag[c]   = PREG_W'(t);
    endtask

    // Walk head forward by n with single-lane dispatch, each completed the following cycle.
    task automatic advance(input int n);
        for (int i = 0; i < n; i++) begin
            idle();
            lane(0, i % 64, 1'b0);
            if (i > 0) cdb_set(0, (i - 1) % 64);
            cyc();
        end
        idle();
        if (n > 0) cdb_set(0, (n - 1) % 64);
        cyc();
        idle();
        cyc();
    endtask

    int dq[$];

    initial begin
        disp_tag = '0; disp_told = '0; disp_arch = '0; disp_pkt = '0; cdb_tag = '0;
        recover_idx = '0;
        idle();
        reset = 1'b1;
        repeat (2) cyc();
        reset = 1'b0;
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_en", retire_en, 0);
        chk("rst_tag0", retire_tag[0], 0);

        // simple flow
        lane(0, 5, 1'b0); lane(1, 6, 1'b0);
        #1;
        chk("s1_stall", disp_stall, 0);
        chk("s1_idx1", disp_idx[1], 1);
        cyc();
        idle(); cdb_set(0, 5); cdb_set(1, 6);
        cyc();
        idle();
        chk("s1_en", retire_en, 2'b11);
        chk("s1_tags", {retire_tag[1], retire_tag[0]}, {6'd6, 6'd5});
        chk("s1_count", count, 0);
        cyc();

        // out-of-order completion
        lane(0, 10, 1'b0); lane(1, 11, 1'b0);
        cyc();
        idle(); cdb_set(0, 11);
        cyc();
        idle();
        chk("ooo_none", retire_en, 0);
        chk("ooo_count", count, 2);
        cdb_set(0, 10);
        cyc();
        idle();
        chk("ooo_both", retire_en, 2'b11);
        chk("ooo_tag0", retire_tag[0], 10);
        cyc();

        // halt
        lane(0, 20, 1'b1); lane(1, 21, 1'b0);
        cyc();
        idle(); cdb_set(0, 20); cdb_set(1, 21);
        cyc();
        idle();
        chk("halt_en", retire_en, 2'b01);
        chk("halt_tag0", retire_tag[0], 20);
        cyc();
        chk("halt_next_en", retire_en, 2'b01);
        chk("halt_next_tag0", retire_tag[0], 21);
        chk("halt_hold_tag1", retire_tag[1], 11);
        cyc();

        // fill and stall (head = 6)
        for (int c = 0; c < 16; c++) begin
            lane(0, 32 + 2 * c, 1'b0); lane(1, 33 + 2 * c, 1'b0);
            cyc();
        end
        idle();
        chk("fill_full", full, 1);
        chk("fill_count", count, 32);
        lane(0, 0, 1'b0); lane(1, 1, 1'b0); cdb_set(0, 32);
        #1;
        chk("full_stall", disp_stall, 1);
        chk("full_idx0", disp_idx[0], 6);
        cyc();
        chk("full_ret1_count", count, 31);
        cdb_valid = '0; cdb_set(0, 33); cdb_set(1, 34);
        #1;
        chk("one_free_stall", disp_stall, 1);
        cyc();
        chk("ret2_count", count, 29);
        cdb_valid = '0;
        #1;
        chk("accept_stall", disp_stall, 0);
        chk("accept_idx0", disp_idx[0], 6);
        cyc();
        idle();
        chk("accept_count", count, 31);
        for (int t = 35; t < 64; t++) dq.push_back(t);
        dq.push_back(0); dq.push_back(1);
        while (dq.size() > 0) begin
            idle();
            cdb_set(0, dq.pop_front());
            if (dq.size() > 0) cdb_set(1, dq.pop_front());
            cyc();
        end
        idle();
        cyc(); cyc();
        chk("drain_empty", empty, 1);

        // wrap: head 8 -> 31
        advance(23);
        chk("wrap_idx0", disp_idx[0], 31);
        chk("wrap_idx1", disp_idx[1], 0);
        lane(0, 40, 1'b0); lane(1, 41, 1'b0);
        cyc();
        idle(); cdb_set(0, 40); cdb_set(1, 41);
        cyc();
        idle();
        chk("wrap_en", retire_en, 2'b11);
        chk("wrap_tag0", retire_tag[0], 40);
        chk("wrap_tag1", retire_tag[1], 41);
        #1;
        chk("wrap_head", disp_idx[0], 1);
        cyc();

        // recovery: head 1 -> 30, ten entries, branch at index 1
        advance(29);
        chk("rec_start_idx", disp_idx[0], 30);
        for (int c = 0; c < 5; c++) begin
            lane(0, 50 + 2 * c, 1'b0); lane(1, 51 + 2 * c, 1'b0);
            cyc();
        end
        idle();
        chk("rec_count10", count, 10);
        recover = 1'b1; recover_idx = 5'd1;
        lane(0, 60, 1'b0); lane(1, 61, 1'b0);
        cyc();
        idle();
`ifdef ROB_SELECTIVE_SQUASH_EN
        chk("rec_count", count, 4);
        chk("rec_tail", disp_idx[0], 2);
        cdb_set(0, 50); cdb_set(1, 51);
        cyc();
        idle(); cdb_set(0, 52); cdb_set(1, 53);
        cyc();
        idle();
        cyc();
        chk("rec_drain_empty", empty, 1);
`else
        chk("rec_count", count, 0);
        chk("rec_empty", empty, 1);
        chk("rec_tail", disp_idx[0], 30);
        cyc();
`endif

        // reset in the middle of traffic
        lane(0, 7, 1'b0); lane(1, 8, 1'b0);
        cyc();
        reset = 1'b1; cdb_set(0, 7);
        cyc();
        reset = 1'b0;
        idle();
        chk("mid_rst_count", count, 0);
        chk("mid_rst_empty", empty, 1);
        chk("mid_rst_en", retire_en, 0);
        cyc(); cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1);
    end

endmodule
